// File: rtl/sha_sched_pkg.sv
// Shared types and width constants for the nonce scheduler.
package sha_sched_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int NONCE_W       = 32;
  localparam int COUNT_W       = 16;
  localparam int H0_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module prio_enc
  import sha_sched_pkg::*;
#(
  parameter int W     = NUM_CORES_DEF,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Dispatches a range of nonces across a pool of shared SHA-256 cores,
// counts completed hashes and captures the first result below target.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cfg_start; results from last job held
// ST_RUN    | issuing nonces to idle cores, lowest index first
// ST_DRAIN  | no more issues; waiting for busy cores to finish
// ST_FINISH | one-cycle done pulse, then back to idle
module nonce_scheduler
  import sha_sched_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_start,
  input  logic [NONCE_W-1:0]        cfg_nonce_base,
  input  logic [COUNT_W-1:0]        cfg_nonce_count,
  input  logic [H0_W-1:0]           cfg_target,
  input  logic                      cfg_abort,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [NONCE_W-1:0]        core_nonce,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [NUM_CORES*H0_W-1:0] core_h0,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic [NONCE_W-1:0]        found_nonce,
  output logic [COUNT_W-1:0]        hash_count
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t               state_q;
  logic [NONCE_W-1:0]   base_q;
  logic [COUNT_W-1:0]   count_q;
  logic [H0_W-1:0]      target_q;
  logic [COUNT_W-1:0]   issued_q;
  logic [NUM_CORES-1:0] core_busy_q;
  logic [NONCE_W-1:0]   nonce_rec [NUM_CORES];

  logic [NUM_CORES-1:0] done_eff;
  logic [NUM_CORES-1:0] busy_after;
  logic [NUM_CORES-1:0] avail;
  logic [NUM_CORES-1:0] hit_vec;
  logic [COUNT_W-1:0]   done_pop;
  logic [IDX_W-1:0]     idle_idx;
  logic                 idle_ok;
  logic [IDX_W-1:0]     hit_idx;
  logic                 hit_ok;
  logic [NONCE_W-1:0]   next_nonce;
  logic                 all_issued;

  // Done pulses only count for cores we actually started; a core freed this
  // cycle is immediately eligible for the next issue.
  always_comb begin
    done_eff   = core_done & core_busy_q;
    busy_after = core_busy_q & ~done_eff;
    avail      = ~busy_after;
    done_pop   = '0;
    hit_vec    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_pop   = done_pop + COUNT_W'(done_eff[i]);
      hit_vec[i] = done_eff[i] && (core_h0[i*H0_W +: H0_W] < target_q);
    end
  end

  assign next_nonce = base_q + NONCE_W'(issued_q);
  assign all_issued = (issued_q == count_q);
  assign busy       = (state_q != ST_IDLE);

  prio_enc #(.W(NUM_CORES), .IDX_W(IDX_W)) u_idle_sel (
    .req   (avail),
    .idx   (idle_idx),
    .valid (idle_ok)
  );

  prio_enc #(.W(NUM_CORES), .IDX_W(IDX_W)) u_hit_sel (
    .req   (hit_vec),
    .idx   (hit_idx),
    .valid (hit_ok)
  );

  // Job sequencing, core dispatch and result accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      target_q    <= '0;
      issued_q    <= '0;
      core_busy_q <= '0;
      core_start  <= '0;
      core_nonce  <= '0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      hash_count  <= '0;
      for (int i = 0; i < NUM_CORES; i++) nonce_rec[i] <= '0;
    end else begin
      core_start  <= '0;
      core_nonce  <= '0;
      done        <= 1'b0;
      core_busy_q <= busy_after;

      if (state_q == ST_RUN || state_q == ST_DRAIN) begin
        hash_count <= hash_count + done_pop;
        if (hit_ok && !found) begin
          found       <= 1'b1;
          found_nonce <= nonce_rec[hit_idx];
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            base_q      <= cfg_nonce_base;
            count_q     <= cfg_nonce_count;
            target_q    <= cfg_target;
            found       <= 1'b0;
            found_nonce <= '0;
            hash_count  <= '0;
            if (cfg_nonce_count == '0) begin
              issued_q <= '0;
              state_q  <= ST_DRAIN;
            end else begin
              // Every core is idle here, so the first issue needs no check.
              core_start             <= NUM_CORES'(1) << idle_idx;
              core_nonce             <= cfg_nonce_base;
              core_busy_q[idle_idx]  <= 1'b1;
              nonce_rec[idle_idx]    <= cfg_nonce_base;
              issued_q               <= COUNT_W'(1);
              state_q                <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cfg_abort || hit_ok || all_issued) begin
            state_q <= ST_DRAIN;
          end else if (idle_ok) begin
            core_start             <= NUM_CORES'(1) << idle_idx;
            core_nonce             <= next_nonce;
            core_busy_q[idle_idx]  <= 1'b1;
            nonce_rec[idle_idx]    <= next_nonce;
            issued_q               <= issued_q + COUNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (busy_after == '0) begin
            state_q <= ST_FINISH;
            done    <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler with a behavioural core pool.
`timescale 1ns/1ps
module tb_nonce_scheduler;

  localparam int NC = 4;

  logic            clk;
  logic            reset_n;
  logic            cfg_start;
  logic [31:0]     cfg_nonce_base;
  logic [15:0]     cfg_nonce_count;
  logic [31:0]     cfg_target;
  logic            cfg_abort;
  logic [NC-1:0]   core_start;
  logic [31:0]     core_nonce;
  logic [NC-1:0]   core_done;
  logic [NC*32-1:0] core_h0;
  logic            busy;
  logic            done;
  logic            found;
  logic [31:0]     found_nonce;
  logic [15:0]     hash_count;

  nonce_scheduler #(.NUM_CORES(NC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_start       (cfg_start),
    .cfg_nonce_base  (cfg_nonce_base),
    .cfg_nonce_count (cfg_nonce_count),
    .cfg_target      (cfg_target),
    .cfg_abort       (cfg_abort),
    .core_start      (core_start),
    .core_nonce      (core_nonce),
    .core_done       (core_done),
    .core_h0         (core_h0),
    .busy            (busy),
    .done            (done),
    .found           (found),
    .found_nonce     (found_nonce),
    .hash_count      (hash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int core; logic [31:0] nonce; } start_t;
  typedef struct { logic f; logic [31:0] fn; logic [15:0] hc; int at; } res_t;

  start_t sq[$];
  res_t   rq[$];

  int n_chk = 0;
  int n_pass = 0;
  int starts_seen = 0;
  int dones_seen = 0;

  int          lat [NC];
  logic [31:0] h0v [NC];
  int          ctr [NC];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic int core_idx(logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Core pool model: fixed per-core latency, fixed per-core h0 result.
  initial begin
    core_done = '0;
    core_h0   = '0;
    for (int i = 0; i < NC; i++) ctr[i] = 0;
    forever begin
      @(negedge clk);
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
        if (ctr[i] > 0) begin
          ctr[i]--;
          if (ctr[i] == 0) begin
            core_done[i]         = 1'b1;
            core_h0[i*32 +: 32]  = h0v[i];
          end
        end
        if (core_start[i] === 1'b1) ctr[i] = lat[i];
      end
    end
  end

  // Monitor: pops expectations whenever the DUT starts a core or signals done.
  initial begin
    start_t s;
    res_t   r;
    logic   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start !== '0) begin
        starts_seen++;
        chk("start_onehot", 32'($onehot(core_start)), 1);
        if (sq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_start: core_start=%b nonce=0x%08h, none expected (cycle %0d)",
                   core_start, core_nonce, cyc);
        end else begin
          s = sq.pop_front();
          chk("start_core", core_idx(core_start), s.core);
          chk("start_nonce", core_nonce, s.nonce);
        end
      end
      if (done === 1'b1) begin
        dones_seen++;
        chk("done_single_cycle", 32'(prev_done), 0);
        chk("busy_at_done", 32'(busy), 1);
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done=1, none expected (cycle %0d)", cyc);
        end else begin
          r = rq.pop_front();
          chk("found", 32'(found), 32'(r.f));
          chk("found_nonce", found_nonce, r.fn);
          chk("hash_count", 32'(hash_count), 32'(r.hc));
          chk("done_cycle", cyc, r.at);
        end
      end
      prev_done = done;
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_job(logic [31:0] base, logic [15:0] cnt, logic [31:0] tgt);
    cfg_nonce_base  = base;
    cfg_nonce_count = cnt;
    cfg_target      = tgt;
    cfg_start       = 1'b1;
    step(1);
    cfg_start       = 1'b0;
  endtask

  task automatic wait_done(int budget, logic [15:0] exp_hc);
    int d0;
    int k;
    d0 = dones_seen;
    k  = 0;
    while (dones_seen == d0 && k < budget) begin
      step(1);
      k++;
    end
    if (dones_seen == d0) begin
      n_chk++;
      $display("FAIL wait_done: no done within %0d cycles, required one", budget);
    end else begin
      chk("idle_after_done_busy", 32'(busy), 0);
      chk("idle_after_done_done", 32'(done), 0);
      step(3);
      chk("hash_count_held", 32'(hash_count), 32'(exp_hc));
    end
  endtask

  task automatic set_pool(int l0, int l1, int l2, int l3,
                          logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    h0v[0] = a;  h0v[1] = b;  h0v[2] = c;  h0v[3] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    reset_n         = 1'b0;
    cfg_start       = 1'b0;
    cfg_abort       = 1'b0;
    cfg_nonce_base  = '0;
    cfg_nonce_count = '0;
    cfg_target      = '0;
    set_pool(5, 5, 5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(3);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_hash_count", 32'(hash_count), 0);
    reset_n = 1'b1;
    step(2);

    // Eight nonces over four cores, nothing below target 0.
    c = cyc;
    for (int k = 0; k < 8; k++) sq.push_back('{k % 4, 32'h100 + 32'(k)});
    rq.push_back('{1'b0, 32'h0, 16'd8, c + 16});
    start_job(32'h0000_0100, 16'd8, 32'h0);
    wait_done(60, 16'd8);

    // Nonce range wrapping past 2^32.
    c = cyc;
    sq.push_back('{0, 32'hFFFF_FFFE});
    sq.push_back('{1, 32'hFFFF_FFFF});
    sq.push_back('{2, 32'h0000_0000});
    sq.push_back('{3, 32'h0000_0001});
    rq.push_back('{1'b0, 32'h0, 16'd4, c + 10});
    start_job(32'hFFFF_FFFE, 16'd4, 32'h0);
    wait_done(60, 16'd4);

    // Cores 1 and 3 hit together; core 0 hits later and must be ignored.
    set_pool(10, 6, 10, 4, 32'h0000_0010, 32'h0000_0500, 32'hFFFF_FFFF, 32'h0000_0500);
    c = cyc;
    for (int k = 0; k < 4; k++) sq.push_back('{k, 32'h2000 + 32'(k)});
    rq.push_back('{1'b1, 32'h0000_2001, 16'd4, c + 14});
    start_job(32'h0000_2000, 16'd8, 32'h0000_1000);
    wait_done(60, 16'd4);
    set_pool(5, 5, 5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Empty job.
    c = cyc;
    rq.push_back('{1'b0, 32'h0, 16'd0, c + 2});
    start_job(32'h1234_5678, 16'd0, 32'hFFFF_FFFF);
    wait_done(20, 16'd0);

    // Abort after three issues, plus a second cfg_start while busy.
    c = cyc;
    for (int k = 0; k < 3; k++) sq.push_back('{k, 32'h300 + 32'(k)});
    rq.push_back('{1'b0, 32'h0, 16'd3, c + 9});
    start_job(32'h0000_0300, 16'd8, 32'h0);
    step(2);
    cfg_abort = 1'b1;
    step(1);
    cfg_abort = 1'b0;
    step(1);
    start_job(32'h0000_9999, 16'd1, 32'hFFFF_FFFF);
    wait_done(60, 16'd3);

    // Abort while idle does nothing.
    cfg_abort = 1'b1;
    step(1);
    cfg_abort = 1'b0;
    step(1);
    chk("abort_idle_busy", 32'(busy), 0);

    // Reset in the middle of a run; the stray done later must be ignored.
    c = cyc;
    sq.push_back('{0, 32'h400});
    start_job(32'h0000_0400, 16'd8, 32'h0);
    step(1);
    reset_n = 1'b0;
    #1;
    chk("midrst_core_start", 32'(core_start), 0);
    chk("midrst_core_nonce", core_nonce, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_found", 32'(found), 0);
    chk("midrst_found_nonce", found_nonce, 0);
    chk("midrst_hash_count", 32'(hash_count), 0);
    step(2);
    reset_n = 1'b1;
    step(8);
    chk("stray_done_hash_count", 32'(hash_count), 0);
    chk("stray_done_busy", 32'(busy), 0);

    // Fresh job after reset; h0 equal to target is not a hit.
    set_pool(5, 5, 5, 5, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    c = cyc;
    sq.push_back('{0, 32'h55});
    sq.push_back('{1, 32'h56});
    rq.push_back('{1'b1, 32'h0000_0056, 16'd2, c + 8});
    start_job(32'h0000_0055, 16'd2, 32'h0000_0080);
    wait_done(60, 16'd2);

    chk("start_queue_empty", sq.size(), 0);
    chk("result_queue_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
